// File: rtl/alarm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_sequencer: multi-channel BCD alarm with snooze, limit and timeout.   |
// | Optional: SNOOZE_SHOW_EN shows snooze_time while waiting. Rev 1.0          |
// +----------------------------------------------------------------------------+
module alarm_sequencer #(
  parameter int NUM_ALARMS       = 2,
  parameter int SEL_W            = 3,
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZES      = 3,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             current_time,
  input  logic                    minute_tick,
  input  logic [16*NUM_ALARMS-1:0] alarm_times,
  input  logic [NUM_ALARMS-1:0]   alarm_enable,
  input  logic                    do_snooze,
  input  logic                    stop_alarm,
  input  logic                    show_alarm,
  input  logic [SEL_W-1:0]        show_sel,
  output logic [15:0]             display,
  output logic                    sound_alarm,
  output logic [SEL_W-1:0]        active_alarm,
  output logic [15:0]             snooze_time,
  output logic [3:0]              snooze_count,
  output logic [1:0]              state_out
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RINGING     = 2'd1,
    SNOOZE_CALC = 2'd2,
    SNOOZE_WAIT = 2'd3
  } state_t;

  localparam int              RC_W     = $clog2(RING_TIMEOUT_MIN + 2);
  localparam logic [RC_W-1:0] RC_LIMIT = RC_W'(RING_TIMEOUT_MIN);
  localparam logic [4:0]      SN_LO    = 5'(SNOOZE_MIN % 10);
  localparam logic [4:0]      SN_HI    = 5'(SNOOZE_MIN / 10);
  localparam logic [3:0]      MAX_CNT  = 4'(MAX_SNOOZES);

  state_t            state;
  logic [RC_W-1:0]   ring_cnt;
  logic              match_any;
  logic [SEL_W-1:0]  match_idx;
  logic              active_en;
  logic              timeout;
  logic [4:0]        ml_sum, mh_sum, hl_sum;
  logic [3:0]        hh_sum;
  logic [15:0]       snooze_next;

  assign state_out = state;
  assign timeout   = (RING_TIMEOUT_MIN != 0) && minute_tick &&
                     ((ring_cnt + RC_W'(1)) == RC_LIMIT);

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    active_en = 1'b0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_enable[i] && (alarm_times[16*i +: 16] == current_time)) begin
        match_any = 1'b1;
        match_idx = SEL_W'(i);
      end
      if (active_alarm == SEL_W'(i)) active_en = alarm_enable[i];
    end
  end

  // Digit-wise BCD add; at most one carry ripples per digit since SNOOZE_MIN < 60.
  always_comb begin
    ml_sum = {1'b0, current_time[3:0]} + SN_LO;
    mh_sum = {1'b0, current_time[7:4]} + SN_HI;
    hl_sum = {1'b0, current_time[11:8]};
    hh_sum = current_time[15:12];
    if (ml_sum >= 5'd10) begin
      ml_sum = ml_sum - 5'd10;
      mh_sum = mh_sum + 5'd1;
    end
    if (mh_sum >= 5'd6) begin
      mh_sum = mh_sum - 5'd6;
      hl_sum = hl_sum + 5'd1;
    end
    if ((hh_sum == 4'd2) && (hl_sum == 5'd4)) begin
      hh_sum = 4'd0;
      hl_sum = 5'd0;
    end else if (hl_sum == 5'd10) begin
      hl_sum = 5'd0;
      hh_sum = hh_sum + 4'd1;
    end
    snooze_next = {hh_sum, hl_sum[3:0], mh_sum[3:0], ml_sum[3:0]};
  end

  always_comb begin
    display = current_time;
    if (show_alarm) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (show_sel == SEL_W'(i)) display = alarm_times[16*i +: 16];
      end
    end
`ifdef SNOOZE_SHOW_EN
    if (show_alarm && (state == SNOOZE_WAIT)) display = snooze_time;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sound_alarm  <= 1'b0;
      active_alarm <= '0;
      snooze_time  <= 16'h0000;
      snooze_count <= 4'd0;
      ring_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (minute_tick && match_any) begin
            state        <= RINGING;
            sound_alarm  <= 1'b1;
            active_alarm <= match_idx;
            snooze_count <= 4'd0;
            ring_cnt     <= '0;
          end
        end
        RINGING: begin
          if (stop_alarm || !active_en || (do_snooze && (snooze_count == MAX_CNT))) begin
            state       <= IDLE;
            sound_alarm <= 1'b0;
          end else if (do_snooze) begin
            state        <= SNOOZE_CALC;
            sound_alarm  <= 1'b0;
            snooze_count <= snooze_count + 4'd1;
          end else if (timeout) begin
            state       <= IDLE;
            sound_alarm <= 1'b0;
          end else if (minute_tick) begin
            ring_cnt <= ring_cnt + RC_W'(1);
          end
        end
        SNOOZE_CALC: begin
          snooze_time <= snooze_next;
          state       <= SNOOZE_WAIT;
        end
        SNOOZE_WAIT: begin
          if (stop_alarm) begin
            state <= IDLE;
          end else if (minute_tick && (current_time == snooze_time)) begin
            state       <= RINGING;
            sound_alarm <= 1'b1;
            ring_cnt    <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          sound_alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
